// File: rtl/forwarding_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : forwarding_hazard_unit_pkg
//  Brief    : Shared forward-select codes, FSM encodings and types for the
//             forwarding / load-use interlock unit.
//  Revision : 1.0  initial release
// ============================================================================
package forwarding_hazard_unit_pkg;

  // Forward select codes driven to the ALU operand muxes
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Interlock FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Remaining-hold counter: LOAD_LAT <= 4 means at most 2 extra HOLD cycles
  localparam int HOLD_W = 2;

  typedef logic [1:0] fwd_sel_t;

endpackage : forwarding_hazard_unit_pkg
`default_nettype wire

// File: rtl/forwarding_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : forwarding_hazard_unit_if
//  Brief    : Pipeline-register side bundle of the forwarding / hazard unit.
//             master = pipeline datapath, slave = hazard unit.
//  Revision : 1.0  initial release
// ============================================================================
interface forwarding_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] id_ex_rs;
  logic [NUM_SRC*REG_AW-1:0] if_id_rs;
  logic [NUM_SRC-1:0]        if_id_rs_used;
  logic                      id_ex_MemRead;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      ex_mem_RegWrite;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic                      mem_wb_RegWrite;
  logic [REG_AW-1:0]         mem_wb_rd;
  logic                      flush;
  logic [2*NUM_SRC-1:0]      forward_sel;
  logic                      stall;
  logic                      bubble;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          fwd_cnt;

  modport master (
    output id_ex_rs, if_id_rs, if_id_rs_used, id_ex_MemRead, id_ex_rd,
           ex_mem_RegWrite, ex_mem_rd, mem_wb_RegWrite, mem_wb_rd, flush,
    input  forward_sel, stall, bubble, stall_cnt, fwd_cnt
  );

  modport slave (
    input  id_ex_rs, if_id_rs, if_id_rs_used, id_ex_MemRead, id_ex_rd,
           ex_mem_RegWrite, ex_mem_rd, mem_wb_RegWrite, mem_wb_rd, flush,
    output forward_sel, stall, bubble, stall_cnt, fwd_cnt
  );
endinterface : forwarding_hazard_unit_if
`default_nettype wire

// File: rtl/forwarding_hazard_unit_fwd_src_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_src_sel
//  Brief    : Forward-select decode for a single ALU source operand.
//             EX/MEM result is newer than MEM/WB, so it wins; r0 never forwards.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_src_sel
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              ex_mem_wr_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic              mem_wb_wr_i,
  input  logic [REG_AW-1:0] mem_wb_rd_i,
  output fwd_sel_t          sel_o
);

  // Priority decode of the two producer stages against this operand
  always_comb begin
    sel_o = FWD_NONE;
    if (ex_mem_wr_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == rs_i)) begin
      sel_o = FWD_EXMEM;
    end else if (mem_wb_wr_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == rs_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule : fwd_src_sel
`default_nettype wire

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : forwarding_hazard_unit
//  Brief    : Operand forwarding selects, load-use interlock FSM and saturating
//             stall / forward event counters for the 5-stage pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  forwarding_hazard_unit_if.slave bus
);

  // First stall cycle is spent in IDLE; HOLD covers the remaining LOAD_LAT-1
  localparam logic              MULTI_CYC = (LOAD_LAT > 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = (LOAD_LAT > 1) ? HOLD_W'(LOAD_LAT - 2) : '0;

  logic [2*NUM_SRC-1:0] sel_raw;
  logic                 hit;
  logic                 stall_w;
  logic [0:0]           state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     fwd_cnt_q, fwd_cnt_d;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_sel #(.REG_AW(REG_AW)) u_sel (
        .rs_i        (bus.id_ex_rs[gi*REG_AW +: REG_AW]),
        .ex_mem_wr_i (bus.ex_mem_RegWrite),
        .ex_mem_rd_i (bus.ex_mem_rd),
        .mem_wb_wr_i (bus.mem_wb_RegWrite),
        .mem_wb_rd_i (bus.mem_wb_rd),
        .sel_o       (sel_raw[2*gi +: 2])
      );
    end
  endgenerate

  // Selects are forced to NONE while reset is asserted
  assign bus.forward_sel = reset ? '0 : sel_raw;

  // Load-use hit: EX-stage load writes a register an ID operand actually reads
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.if_id_rs_used[i] && (bus.if_id_rs[i*REG_AW +: REG_AW] == bus.id_ex_rd)) begin
        hit = 1'b1;
      end
    end
    if (!bus.id_ex_MemRead || (bus.id_ex_rd == '0)) begin
      hit = 1'b0;
    end
  end

  // Interlock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Interlock next-state: flush always returns to IDLE and beats a hit
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit && MULTI_CYC) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_INIT;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Interlock outputs: gated by reset so they drop immediately on assertion
  always_comb begin
    stall_w = 1'b0;
    if (!reset && !bus.flush) begin
      case (state_q)
        ST_IDLE: stall_w = hit;
        ST_HOLD: stall_w = 1'b1;
        default: stall_w = 1'b0;
      endcase
    end
  end

  assign bus.stall  = stall_w;
  assign bus.bubble = stall_w;

  // Performance counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  // Saturating increments; counters stick at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_w && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if ((|bus.forward_sel) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;

endmodule : forwarding_hazard_unit
`default_nettype wire
